// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider types: default width, fixup FSM states, result record
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIX  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;
    logic                 div_zero;
    logic                 overflow;
  } div_result_t;

endpackage

// File: rtl/div_result_fifo.sv
// rtl/div_result_fifo.sv - synchronous FIFO of packed result records
module div_result_fifo #(
  parameter int DATA_W = 66,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one popped this same cycle.
  assign do_push = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/signed_div_result_fixup.sv
// rtl/signed_div_result_fixup.sv - converts unsigned divider magnitudes into
// truncating signed quotient/remainder with zero/overflow flags, buffered to the consumer
module signed_div_result_fixup
  import div_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-2:0] in_r,
  input  logic             in_n_sign,
  input  logic             in_d_sign,
  input  logic             in_div_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_div_zero,
  output logic             out_overflow
);

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;
    logic             overflow;
  } fix_result_t;

  localparam int RES_W = $bits(fix_result_t);
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-2:0] cap_r;
  logic             cap_n_sign;
  logic             cap_d_sign;
  logic             cap_div_zero;
  fix_result_t      stage;
  fix_result_t      fixed;
  fix_result_t      head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = (state == S_PUSH) && (!fifo_full || fifo_pop);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_PUSH;
      S_PUSH:  if (fifo_push) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Quotient sign is the XOR of operand signs; the remainder follows the dividend.
  always_comb begin
    logic             q_neg;
    logic [WIDTH-1:0] r_ext;
    q_neg          = cap_n_sign ^ cap_d_sign;
    r_ext          = {1'b0, cap_r};
    fixed.q        = q_neg ? (~cap_q + 1'b1) : cap_q;
    fixed.r        = (cap_n_sign && (cap_r != '0)) ? (~r_ext + 1'b1) : r_ext;
    fixed.div_zero = 1'b0;
    fixed.overflow = 1'b0;
    if (cap_div_zero) begin
      fixed.q        = '0;
      fixed.r        = '0;
      fixed.div_zero = 1'b1;
    end else if (!q_neg && (cap_q == Q_MIN)) begin
      fixed.q        = Q_MAX;
      fixed.r        = '0;
      fixed.overflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cap_q        <= '0;
      cap_r        <= '0;
      cap_n_sign   <= 1'b0;
      cap_d_sign   <= 1'b0;
      cap_div_zero <= 1'b0;
      stage        <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid) begin
        cap_q        <= in_q;
        cap_r        <= in_r;
        cap_n_sign   <= in_n_sign;
        cap_d_sign   <= in_d_sign;
        cap_div_zero <= in_div_zero;
      end
      if (state == S_FIX) begin
        stage <= fixed;
      end
    end
  end

  div_result_fifo #(
    .DATA_W (RES_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (stage),
    .pop       (fifo_pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_q        = head.q;
  assign out_r        = head.r;
  assign out_div_zero = head.div_zero;
  assign out_overflow = head.overflow;

endmodule

// File: tb/tb_signed_div_result_fixup.sv
// tb/tb_signed_div_result_fixup.sv - directed self-checking bench for signed_div_result_fixup
module tb_signed_div_result_fixup;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_q;
  logic [30:0] in_r;
  logic        in_n_sign;
  logic        in_d_sign;
  logic        in_div_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [31:0] out_r;
  logic        out_div_zero;
  logic        out_overflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  signed_div_result_fixup #(.WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_q         (in_q),
    .in_r         (in_r),
    .in_n_sign    (in_n_sign),
    .in_d_sign    (in_d_sign),
    .in_div_zero  (in_div_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_q        (out_q),
    .out_r        (out_r),
    .out_div_zero (out_div_zero),
    .out_overflow (out_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic dz, input logic ov);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_q"}, 64'(out_q), 64'(q));
    check({tag, "_r"}, 64'(out_r), 64'(r));
    check({tag, "_dz"}, 64'(out_div_zero), 64'(dz));
    check({tag, "_ov"}, 64'(out_overflow), 64'(ov));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] q, input logic [30:0] r, input logic ns,
                      input logic ds, input logic dz);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      mismatched++;
      $error("FAIL send_timeout observed=in_ready=0 expected=in_ready=1");
    end
    in_valid    = 1'b1;
    in_q        = q;
    in_r        = r;
    in_n_sign   = ns;
    in_d_sign   = ds;
    in_div_zero = dz;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      mismatched++;
      $error("FAIL wait_valid_timeout observed=out_valid=0 expected=out_valid=1");
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_q = '0; in_r = '0; in_n_sign = 1'b0; in_d_sign = 1'b0; in_div_zero = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_out_r", 64'(out_r), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    send(32'd3, 31'd1, 1'b1, 1'b0, 1'b0);
    wait_valid();
    check_res("n7_d2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    pop_one();

    send(32'd3, 31'd1, 1'b0, 1'b1, 1'b0);
    wait_valid();
    check_res("p7_dn2", 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0);
    pop_one();

    send(32'd2, 31'd0, 1'b1, 1'b1, 1'b0);
    wait_valid();
    check_res("n6_dn3", 32'd2, 32'd0, 1'b0, 1'b0);
    pop_one();

    send(32'h8000_0000, 31'd0, 1'b1, 1'b1, 1'b0);
    wait_valid();
    check_res("ovf", 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);
    pop_one();

    send(32'h8000_0000, 31'd0, 1'b1, 1'b0, 1'b0);
    wait_valid();
    check_res("min_ok", 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    pop_one();

    // divide-by-zero, plus exact two-edge latency from acceptance
    send(32'd1234, 31'd55, 1'b1, 1'b0, 1'b1);
    check("dz_lat_e0", 64'(out_valid), 64'd0);
    tick();
    check("dz_lat_e1", 64'(out_valid), 64'd0);
    tick();
    check_res("dz", 32'd0, 32'd0, 1'b1, 1'b0);
    pop_one();
    check("dz_drained", 64'(out_valid), 64'd0);

    // backpressure: two buffered, third parked in S_PUSH
    send(32'd10, 31'd1, 1'b0, 1'b0, 1'b0);
    send(32'd20, 31'd2, 1'b1, 1'b1, 1'b0);
    send(32'd30, 31'd3, 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check_res("bp_head0", 32'd10, 32'd1, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_res("bp_head1", 32'd20, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("bp_in_ready_after_pop", 64'(in_ready), 64'd1);
    tick();
    check_res("bp_head2", 32'hFFFF_FFE2, 32'd3, 1'b0, 1'b0);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // reset while one result buffered and another in S_FIX
    send(32'd5, 31'd0, 1'b0, 1'b0, 1'b0);
    wait_valid();
    check_res("mid_pre", 32'd5, 32'd0, 1'b0, 1'b0);
    send(32'd9, 31'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    check("mid_out_q", 64'(out_q), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_no_stale", 64'(out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
